// File: rtl/expansao_chave_pkg.sv
// Shared AES-128 key schedule definitions: widths, round count,
// FSM encoding, RCON table and the caixaS S-box used by substituiBytes.
package expansao_chave_pkg;

    localparam int NUM_RODADAS  = 10;
    localparam int LARG_PALAVRA = 32;
    localparam int LARG_CHAVE   = 128;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        EMITINDO  = 2'd1,
        CONCLUIDO = 2'd2
    } estado_t;

    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Row i holds S(16*i) .. S(16*i+15), first byte at the left.
    localparam logic [0:255][7:0] CAIXA_S = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constant for round r (1..10); zero outside the table.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            if (r == 4'(i)) v = RCON[i];
        end
        return v;
    endfunction

endpackage

// File: rtl/expansao_chave_substitui_palavra.sv
// SubWord: applies caixaS to each byte of a 32-bit word.
// Ports: palavra (in, 32) -> saida (out, 32), purely combinational.
module substitui_palavra
    import expansao_chave_pkg::*;
(
    input  logic [LARG_PALAVRA-1:0] palavra,
    output logic [LARG_PALAVRA-1:0] saida
);

    assign saida = {
        CAIXA_S[palavra[31:24]],
        CAIXA_S[palavra[23:16]],
        CAIXA_S[palavra[15:8]],
        CAIXA_S[palavra[7:0]]
    };

endmodule

// File: rtl/expansao_chave.sv
// Iterative AES-128 key schedule: emits round keys 0..10 one per
// valid/ready handshake. Ports: clk, rst_n, iniciar, chave[127:0] in;
// chave_rodada[127:0], indice_rodada[3:0], chave_valida out;
// chave_pronta in; ocupado, fim out.
module expansao_chave
    import expansao_chave_pkg::*;
#(
    parameter int NUM_RODADAS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iniciar,
    input  logic [LARG_CHAVE-1:0] chave,
    output logic [LARG_CHAVE-1:0] chave_rodada,
    output logic [3:0]            indice_rodada,
    output logic                  chave_valida,
    input  logic                  chave_pronta,
    output logic                  ocupado,
    output logic                  fim
);

    if (NUM_RODADAS != expansao_chave_pkg::NUM_RODADAS) begin : g_rodadas
        $error("expansao_chave: only AES-128 (NUM_RODADAS=10) is supported");
    end

    localparam logic [3:0] ULTIMA = 4'(NUM_RODADAS);

    estado_t estado, prox_estado;

    logic                    carrega;
    logic                    avanca;
    logic                    handshake;
    logic [LARG_PALAVRA-1:0] w0, w1, w2, w3;
    logic [LARG_PALAVRA-1:0] w4, w5, w6, w7;
    logic [LARG_PALAVRA-1:0] rotacionada;
    logic [LARG_PALAVRA-1:0] substituida;
    logic [LARG_PALAVRA-1:0] t;
    logic [3:0]              prox_indice;

    assign {w0, w1, w2, w3} = chave_rodada;
    assign rotacionada = {w3[23:0], w3[31:24]};
    assign prox_indice = indice_rodada + 4'd1;

    substitui_palavra u_sub (
        .palavra (rotacionada),
        .saida   (substituida)
    );

    assign t  = substituida ^ {rcon(prox_indice), 24'h0};
    assign w4 = w0 ^ t;
    assign w5 = w1 ^ w4;
    assign w6 = w2 ^ w5;
    assign w7 = w3 ^ w6;

    assign handshake = chave_valida & chave_pronta;

    always_comb begin
        prox_estado = estado;
        carrega     = 1'b0;
        avanca      = 1'b0;
        unique case (estado)
            OCIOSO: begin
                if (iniciar) begin
                    prox_estado = EMITINDO;
                    carrega     = 1'b1;
                end
            end
            EMITINDO: begin
                if (handshake) begin
                    if (indice_rodada == ULTIMA) prox_estado = CONCLUIDO;
                    else avanca = 1'b1;
                end
            end
            CONCLUIDO: prox_estado = OCIOSO;
            default:   prox_estado = OCIOSO;
        endcase
    end

    // Flags are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado        <= OCIOSO;
            chave_rodada  <= '0;
            indice_rodada <= '0;
            chave_valida  <= 1'b0;
            ocupado       <= 1'b0;
            fim           <= 1'b0;
        end else begin
            estado       <= prox_estado;
            chave_valida <= (prox_estado == EMITINDO);
            ocupado      <= (prox_estado != OCIOSO);
            fim          <= (prox_estado == CONCLUIDO);
            if (carrega) begin
                chave_rodada  <= chave;
                indice_rodada <= 4'd0;
            end else if (avanca) begin
                chave_rodada  <= {w4, w5, w6, w7};
                indice_rodada <= prox_indice;
            end
        end
    end

endmodule

// File: tb/tb_expansao_chave.sv
// Self-checking bench for expansao_chave against a GF(2^8)-derived
// key schedule model plus FIPS-197 known answers.
module tb_expansao_chave;

    localparam logic [127:0] K_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_R2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         iniciar;
    logic [127:0] chave;
    logic [127:0] chave_rodada;
    logic [3:0]   indice_rodada;
    logic         chave_valida;
    logic         chave_pronta;
    logic         ocupado;
    logic         fim;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   sb       [256];
    logic [127:0] modelo   [11];
    logic [127:0] recebida [11];

    expansao_chave dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .iniciar       (iniciar),
        .chave         (chave),
        .chave_rodada  (chave_rodada),
        .indice_rodada (indice_rodada),
        .chave_valida  (chave_valida),
        .chave_pronta  (chave_pronta),
        .ocupado       (ocupado),
        .fim           (fim)
    );

    always #5 clk = ~clk;

    task automatic verifica(input string tag,
                            input logic [127:0] obs,
                            input logic [127:0] esp);
        checks++;
        if (obs !== esp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, esp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse, then affine map.
    task automatic monta_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ 8'h63;
            for (int n = 1; n <= 4; n++) begin
                s = s ^ 8'((inv << n) | (inv >> (8 - n)));
            end
            sb[x] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    task automatic gera_modelo(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++)
            modelo[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // modo 0: plain run; 1: stray iniciar at round 4 and in the fim
    // cycle; 2: reset at round 6. imediato: start at the current negedge.
    task automatic expande(input logic [127:0] k, input bit aleatorio,
                           input int modo, input bit imediato);
        int           cyc    = 0;
        int           idx    = 0;
        int           stalls = 0;
        bit           parado = 0;
        bit           feito  = 0;
        logic [127:0] pk     = '0;
        logic [3:0]   pi     = '0;
        gera_modelo(k);
        for (int r = 0; r < 11; r++) recebida[r] = '0;
        if (!imediato) @(negedge clk);
        chave        = k;
        iniciar      = 1'b1;
        chave_pronta = aleatorio ? 1'($urandom % 2) : 1'b1;
        while (!feito && cyc < 200) begin
            @(negedge clk);
            cyc++;
            iniciar = 1'b0;
            if (modo == 2 && idx == 6 && chave_valida) begin
                rst_n = 1'b0;
                #1;
                verifica("rst_chave", chave_rodada, '0);
                verifica("rst_indice", indice_rodada, 0);
                verifica("rst_valida", chave_valida, 0);
                verifica("rst_ocupado", ocupado, 0);
                verifica("rst_fim", fim, 0);
                repeat (3) begin
                    @(negedge clk);
                    verifica("rst_sem_fim", fim, 0);
                end
                rst_n = 1'b1;
                feito = 1;
            end else if (fim) begin
                verifica("fim_ciclo", cyc, 12 + stalls);
                verifica("fim_rodadas", idx, 11);
                verifica("fim_valida", chave_valida, 0);
                if (modo == 1) begin
                    iniciar = 1'b1;
                    chave   = '0;
                    @(negedge clk);
                    iniciar = 1'b0;
                    verifica("pos_fim_ocupado", ocupado, 0);
                    verifica("pos_fim_valida", chave_valida, 0);
                end
                feito = 1;
            end else if (chave_valida) begin
                if (parado) begin
                    verifica("estavel_chave", chave_rodada, pk);
                    verifica("estavel_indice", indice_rodada, pi);
                end
                verifica($sformatf("chave_r%0d", idx), chave_rodada, modelo[idx]);
                verifica("indice", indice_rodada, idx);
                verifica("ocupado", ocupado, 1);
                recebida[idx] = chave_rodada;
                if (modo == 1 && idx == 4) begin
                    iniciar = 1'b1;
                    chave   = '0;
                end
                chave_pronta = aleatorio ? 1'($urandom % 2) : 1'b1;
                parado = !chave_pronta;
                pk = chave_rodada;
                pi = indice_rodada;
                if (chave_pronta) idx++;
                else stalls++;
            end else begin
                verifica("valida_caiu", chave_valida, 1);
            end
        end
        verifica("timeout", feito, 1);
    endtask

    initial begin
        rst_n        = 1'b0;
        iniciar      = 1'b0;
        chave        = '0;
        chave_pronta = 1'b0;
        monta_sbox();
        repeat (2) @(negedge clk);
        verifica("reset_chave", chave_rodada, '0);
        verifica("reset_indice", indice_rodada, 0);
        verifica("reset_valida", chave_valida, 0);
        verifica("reset_ocupado", ocupado, 0);
        verifica("reset_fim", fim, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chave_pronta = 1'b1;
        repeat (2) @(negedge clk);
        verifica("ocioso_valida", chave_valida, 0);
        verifica("ocioso_indice", indice_rodada, 0);
        verifica("ocioso_ocupado", ocupado, 0);

        expande(K_A1, 0, 0, 0);
        verifica("a1_r0", recebida[0], K_A1);
        verifica("a1_r1", recebida[1], A1_R1);
        verifica("a1_r10", recebida[10], A1_RA);

        expande('0, 0, 0, 0);
        verifica("zero_r1", recebida[1], Z_R1);
        verifica("zero_r2", recebida[2], Z_R2);

        expande(K_A1, 1, 0, 0);
        verifica("rand_r1", recebida[1], A1_R1);
        verifica("rand_r10", recebida[10], A1_RA);

        expande(K_A1, 0, 1, 0);
        verifica("ignora_r10", recebida[10], A1_RA);
        expande(K_A1, 0, 0, 1);
        verifica("reinicio_r0", recebida[0], K_A1);

        expande(K_A1, 1, 2, 0);
        expande(K_A1, 0, 0, 0);
        verifica("pos_rst_r0", recebida[0], K_A1);
        verifica("pos_rst_r10", recebida[10], A1_RA);

        for (int n = 0; n < 3; n++) begin
            expande({$urandom, $urandom, $urandom, $urandom}, 1, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
